// File: rtl/uart_rx.sv
// uart_rx: 8-bit UART receiver with a small receive FIFO and an rtr flow-control output.
// Latency: a byte is visible on valid_o/data_o one clk_i cycle after its mid-stop-bit sample.
// Backpressure: rtr_o drops once fewer than 2 entries are free; a byte arriving to a full FIFO is dropped (overrun_o).
//
// Ports:
//   clk_i        single clock, rising edge
//   rst_i        synchronous active-high reset
//   rx_i         asynchronous serial input, idle high
//   rtr_o        ready-to-receive, drives the peer's cts_i
//   data_o       FIFO head byte (8'h00 while empty)
//   valid_o      FIFO not empty
//   ready_i      consumer accepts data_o; pop when valid_o && ready_i
//   frame_err_o  one-cycle pulse: bad stop bit (or bad parity)
//   overrun_o    one-cycle pulse: good byte dropped because the FIFO was full
//
// Optional feature: define UART_RX_PARITY_EN for 8E1 framing (even parity bit
// between data and stop). Without it the receiver is 8N1.

module uart_rx #(
  parameter int CLK_DIV    = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_i,
  output logic       rtr_o,
  output logic [7:0] data_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       frame_err_o,
  output logic       overrun_o
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [15:0] HALF_M1 = 16'(CLK_DIV / 2 - 1);
  localparam logic [15:0] FULL_M1 = 16'(CLK_DIV - 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] RTR_LIMIT = CW'(FIFO_DEPTH - 2);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  // ---------------------------------------------------------------
  // Synchronizer and start-edge detection
  // ---------------------------------------------------------------
  logic       rx_s1, rx_s2;
  logic       rx_prev;
  logic [1:0] warm;

  // The synchronizer flops come out of reset at 1, so for two cycles rx_s2
  // does not reflect the real line. warm[1] marks when it does; until then
  // rx_prev is held low so a line that is already low after reset never
  // looks like a fresh high-to-low transition.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b0;
      warm    <= 2'b00;
    end else begin
      rx_s1   <= rx_i;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2 & warm[1];
      warm    <= {warm[0], 1'b1};
    end
  end

  logic start_edge;
  assign start_edge = rx_prev & ~rx_s2;

  // ---------------------------------------------------------------
  // Receive FSM
  // ---------------------------------------------------------------
  state_t      state, state_d;
  logic [15:0] cnt, cnt_d;
  logic [2:0]  bit_idx, bit_d;
  logic [7:0]  shreg, shreg_d;
  logic        byte_done;
  logic        byte_good;
`ifdef UART_RX_PARITY_EN
  logic        par_bit, par_d;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
`ifdef UART_RX_PARITY_EN
      par_bit <= 1'b0;
`endif
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      bit_idx <= bit_d;
      shreg   <= shreg_d;
`ifdef UART_RX_PARITY_EN
      par_bit <= par_d;
`endif
    end
  end

  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    bit_d     = bit_idx;
    shreg_d   = shreg;
    byte_done = 1'b0;
    byte_good = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d     = par_bit;
`endif
    case (state)
      IDLE: begin
        if (start_edge) begin
          state_d = START;
          cnt_d   = HALF_M1;
        end
      end
      START: begin
        if (cnt == 16'd0) begin
          // Line back high at mid-start means it was a glitch.
          if (!rx_s2) begin
            state_d = DATA;
            cnt_d   = FULL_M1;
            bit_d   = 3'd0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt - 16'd1;
        end
      end
      DATA: begin
        if (cnt == 16'd0) begin
          shreg_d = {rx_s2, shreg[7:1]};
          cnt_d   = FULL_M1;
          if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_idx + 3'd1;
          end
        end else begin
          cnt_d = cnt - 16'd1;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt == 16'd0) begin
          par_d   = rx_s2;
          cnt_d   = FULL_M1;
          state_d = STOP;
        end else begin
          cnt_d = cnt - 16'd1;
        end
      end
`endif
      STOP: begin
        // Decide at mid-stop and return to IDLE immediately so the next
        // start edge can be caught on the following cycle.
        if (cnt == 16'd0) begin
          byte_done = 1'b1;
`ifdef UART_RX_PARITY_EN
          byte_good = rx_s2 & ~(^shreg ^ par_bit);
`else
          byte_good = rx_s2;
`endif
          state_d   = IDLE;
        end else begin
          cnt_d = cnt - 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------
  // Receive FIFO
  // ---------------------------------------------------------------
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, pop, push_ok, overrun_d;

  assign full      = (count == DEPTH_C);
  assign valid_o   = (count != '0);
  assign data_o    = valid_o ? mem[rd_ptr] : 8'h00;
  assign pop       = valid_o & ready_i;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign push_ok   = byte_good & (~full | pop);
  assign overrun_d = byte_good & full & ~pop;

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem[wr_ptr] <= shreg;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      rtr_o       <= 1'b0;
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      // Two free entries leave room for a byte already in flight when rtr drops.
      rtr_o       <= (count <= RTR_LIMIT);
      frame_err_o <= byte_done & ~byte_good;
      overrun_o   <= overrun_d;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int CLK_DIV    = 16;
  localparam int FIFO_DEPTH = 4;
`ifdef UART_RX_PARITY_EN
  localparam bit PARITY = 1'b1;
`else
  localparam bit PARITY = 1'b0;
`endif

  logic       clk_i   = 1'b0;
  logic       rst_i   = 1'b1;
  logic       rx_i    = 1'b1;
  logic       ready_i = 1'b0;
  logic       rtr_o;
  logic [7:0] data_o;
  logic       valid_o;
  logic       frame_err_o;
  logic       overrun_o;

  uart_rx #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .rx_i        (rx_i),
    .rtr_o       (rtr_o),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .frame_err_o (frame_err_o),
    .overrun_o   (overrun_o)
  );

  always #5 clk_i = ~clk_i;

  int         tests = 0;
  int         fails = 0;
  int         ferr_cnt = 0;
  int         ovr_cnt  = 0;
  int         pop_cnt  = 0;
  bit         both_seen = 1'b0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: outputs sampled mid-cycle; a pop happens at the next rising edge.
  always @(negedge clk_i) begin : mon
    logic [7:0] e;
    if (frame_err_o === 1'b1) ferr_cnt++;
    if (overrun_o === 1'b1) ovr_cnt++;
    if (frame_err_o === 1'b1 && overrun_o === 1'b1) both_seen = 1'b1;
    if (valid_o === 1'b1 && ready_i === 1'b1) begin
      pop_cnt++;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_pop: got %0h expected no byte", data_o);
      end else begin
        e = exp_q.pop_front();
        check("pop_data", {24'h0, data_o}, {24'h0, e});
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic send_bit(input logic v);
    rx_i = v;
    repeat (CLK_DIV) tick();
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_bad);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    if (PARITY) send_bit(^d ^ par_bad);
    send_bit(stop);
    rx_i = 1'b1;
  endtask

  task automatic clear_counts();
    ferr_cnt = 0;
    ovr_cnt  = 0;
    pop_cnt  = 0;
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       par_bad;
    int         exp_ferr;
    int         exp_pops;
  } vec_t;

  vec_t vecs[$];

  initial begin
    vecs.push_back('{8'hA5, 1'b1, 1'b0, 0, 1});
    vecs.push_back('{8'h3C, 1'b0, 1'b0, 1, 0});
    vecs.push_back('{8'h81, 1'b1, 1'b0, 0, 1});
    vecs.push_back('{8'h00, 1'b1, 1'b0, 0, 1});
    vecs.push_back('{8'hFF, 1'b1, 1'b0, 0, 1});
    vecs.push_back('{8'h5A, 1'b0, 1'b0, 1, 0});
    vecs.push_back('{8'hC3, 1'b1, 1'b0, 0, 1});
    if (PARITY) begin
      vecs.push_back('{8'h07, 1'b1, 1'b0, 0, 1});
      vecs.push_back('{8'h07, 1'b1, 1'b1, 1, 0});
      vecs.push_back('{8'h07, 1'b0, 1'b1, 1, 0});
    end

    // Reset values
    rst_i = 1'b1;
    repeat (3) tick();
    check("rst_rtr",   {31'h0, rtr_o},       32'h0);
    check("rst_valid", {31'h0, valid_o},     32'h0);
    check("rst_data",  {24'h0, data_o},      32'h0);
    check("rst_ferr",  {31'h0, frame_err_o}, 32'h0);
    check("rst_ovr",   {31'h0, overrun_o},   32'h0);
    rst_i = 1'b0;
    @(negedge clk_i);
    check("rtr_cycle1", {31'h0, rtr_o}, 32'h0);
    tick();
    check("rtr_cycle2", {31'h0, rtr_o}, 32'h1);
    send_bit(1'b1);

    // Table-driven frames with the consumer always ready
    ready_i = 1'b1;
    foreach (vecs[k]) begin
      clear_counts();
      if (vecs[k].exp_pops != 0) exp_q.push_back(vecs[k].data);
      send_frame(vecs[k].data, vecs[k].stop, vecs[k].par_bad);
      send_bit(1'b1);
      send_bit(1'b1);
      check("row_ferr", ferr_cnt, vecs[k].exp_ferr);
      check("row_ovr",  ovr_cnt, 0);
      check("row_pops", pop_cnt, vecs[k].exp_pops);
    end

    // Short low glitch is ignored; the following byte is received normally
    clear_counts();
    rx_i = 1'b0;
    repeat (5) tick();
    rx_i = 1'b1;
    repeat (3 * CLK_DIV) tick();
    check("glitch_ferr", ferr_cnt, 0);
    check("glitch_pops", pop_cnt, 0);
    exp_q.push_back(8'h96);
    send_frame(8'h96, 1'b1, 1'b0);
    send_bit(1'b1);
    check("post_glitch_pops", pop_cnt, 1);

    // Back-to-back bytes with no consumer: rtr drop and overrun
    clear_counts();
    ready_i = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      if (k <= 4) exp_q.push_back(8'(k));
      send_frame(8'(k), 1'b1, 1'b0);
      if (k == 2) check("rtr_after_2", {31'h0, rtr_o}, 32'h1);
      if (k == 3) check("rtr_after_3", {31'h0, rtr_o}, 32'h0);
    end
    send_bit(1'b1);
    check("ovr_count",  ovr_cnt, 1);
    check("ovr_ferr",   ferr_cnt, 0);
    check("full_valid", {31'h0, valid_o}, 32'h1);
    check("full_head",  {24'h0, data_o}, 32'h01);
    check("full_pops",  pop_cnt, 0);
    ready_i = 1'b1;
    repeat (10) tick();
    check("drain_pops",  pop_cnt, 4);
    check("drain_valid", {31'h0, valid_o}, 32'h0);
    check("drain_rtr",   {31'h0, rtr_o}, 32'h1);

    // Reset during bit 4 of 8'hFF aborts the frame
    clear_counts();
    rx_i = 1'b0;
    repeat (CLK_DIV) tick();
    rx_i = 1'b1;
    repeat (4 * CLK_DIV + CLK_DIV / 2) tick();
    rst_i = 1'b1;
    repeat (2) tick();
    check("midrst_valid", {31'h0, valid_o}, 32'h0);
    check("midrst_rtr",   {31'h0, rtr_o}, 32'h0);
    check("midrst_data",  {24'h0, data_o}, 32'h0);
    check("midrst_ferr",  {31'h0, frame_err_o}, 32'h0);
    check("midrst_ovr",   {31'h0, overrun_o}, 32'h0);
    rst_i = 1'b0;
    repeat (6 * CLK_DIV) tick();
    check("midrst_no_ferr", ferr_cnt, 0);
    check("midrst_no_pop",  pop_cnt, 0);
    exp_q.push_back(8'h42);
    send_frame(8'h42, 1'b1, 1'b0);
    send_bit(1'b1);
    check("post_rst_pops", pop_cnt, 1);
    check("post_rst_ferr", ferr_cnt, 0);

    // Line held low across reset is not a start edge
    clear_counts();
    rx_i = 1'b0;
    repeat (4) tick();
    rst_i = 1'b1;
    repeat (2) tick();
    rst_i = 1'b0;
    repeat (40) tick();
    rx_i = 1'b1;
    repeat (3 * CLK_DIV) tick();
    check("lowrst_ferr", ferr_cnt, 0);
    check("lowrst_pops", pop_cnt, 0);
    exp_q.push_back(8'hE7);
    send_frame(8'hE7, 1'b1, 1'b0);
    send_bit(1'b1);
    check("lowrst_next_pops", pop_cnt, 1);

    check("no_simult_pulses", {31'h0, both_seen}, 32'h0);
    check("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
